fpdiv_iter: RTL and testbench

- Iterative, handshaked IEEE-754-style floating-point divider, parametrised in exponent and mantissa width.
- Sequential successor to the single-precision combinational divider.
- Produces one quotient bit per cycle using a restoring radix-2 recurrence.
- Handles special operands and returns exception flags.
- Sits behind a valid/ready producer and feeds a valid/ready consumer (FPU issue/writeback).

---
 rtl/fpdiv_pkg.sv | 41 ++++
 rtl/fpdiv_classify.sv | 30 +++
 rtl/fpdiv_iter.sv | 208 ++++++++++++++++++++
 tb/tb_fpdiv_iter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fpdiv_pkg.sv
// Shared types, flag indices and special-value builders for the iterative divider.
// Builders return a 64-bit pattern; callers cast to 1+EXP_W+MAN_W (which must be <= 64).
package fpdiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_ITER  = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } fpdiv_state_t;

  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIV_ZERO  = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic logic [63:0] fp_exp_ones(input int exp_w, input int man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return fp_exp_ones(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [63:0] fp_inf(input logic sign, input int exp_w, input int man_w);
    return (64'(sign) << (exp_w + man_w)) | fp_exp_ones(exp_w, man_w);
  endfunction

  function automatic logic [63:0] fp_zero(input logic sign, input int exp_w, input int man_w);
    return 64'(sign) << (exp_w + man_w);
  endfunction

  function automatic logic [63:0] fp_max_finite(input logic sign, input int exp_w, input int man_w);
    return (64'(sign) << (exp_w + man_w))
         | (((64'd1 << exp_w) - 64'd2) << man_w)
         | ((64'd1 << man_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fpdiv_classify.sv
// Combinational operand classifier; takes the magnitude {exp, man} only.
module fpdiv_classify #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W-1:0] mag,
  output logic                   is_zero,
  output logic                   is_inf,
  output logic                   is_nan,
  output logic                   is_sub
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             exp_max;
  logic             exp_min;
  logic             man_nz;

  assign exp_f   = mag[MAN_W +: EXP_W];
  assign man_f   = mag[MAN_W-1:0];
  assign exp_max = &exp_f;
  assign exp_min = ~|exp_f;
  assign man_nz  = |man_f;

  assign is_zero = exp_min & ~man_nz;
  assign is_sub  = exp_min & man_nz;
  assign is_inf  = exp_max & ~man_nz;
  assign is_nan  = exp_max & man_nz;

endmodule

// File: rtl/fpdiv_iter.sv
// Iterative restoring radix-2 floating-point divider with valid/ready handshakes.
// Optional round-to-nearest-even when FPDIV_ITER_ROUND_EN is defined; truncation otherwise.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// PREP  | classify operands, align significands, form working exponent
// ITER  | one quotient bit per cycle, MAN_W+2 cycles
// ROUND | round/normalise, range check, load result (specials pass through)
// DONE  | out_valid=1, result held until out_ready
module fpdiv_iter
  import fpdiv_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   dividend,
  input  logic [EXP_W+MAN_W:0]   divisor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   quotient,
  output logic [4:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int RW = MAN_W + 2;
  localparam int QW = MAN_W + 2;
  localparam int XW = EXP_W + 2;
  localparam int CW = $clog2(QW + 1);
  localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

  fpdiv_state_t state;

  logic [W-1:0]           a_q, b_q;
  logic [RW-1:0]          rem;
  logic [SW-1:0]          div_sig;
  logic [QW-1:0]          q_bits;
  logic signed [XW-1:0]   exp_work;
  logic                   sign_q;
  logic [CW-1:0]          cnt;
  logic                   bypass;
  logic [W-1:0]           spec_q;
  logic [4:0]             spec_fq;

  logic a_zero, a_inf, a_nan, a_sub;
  logic b_zero, b_inf, b_nan, b_sub;

  fpdiv_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .mag(a_q[W-2:0]), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan), .is_sub(a_sub)
  );
  fpdiv_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .mag(b_q[W-2:0]), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan), .is_sub(b_sub)
  );

  // Subnormals are flushed to zero before classification.
  logic a_z, b_z, sgn, special;
  logic [W-1:0] spec_res;
  logic [4:0]   spec_flg;
  logic [SW-1:0] sig1, sig2;
  logic signed [XW-1:0] exp_pre;

  assign a_z     = a_zero | a_sub;
  assign b_z     = b_zero | b_sub;
  assign sgn     = a_q[W-1] ^ b_q[W-1];
  assign sig1    = {1'b1, a_q[MAN_W-1:0]};
  assign sig2    = {1'b1, b_q[MAN_W-1:0]};
  assign exp_pre = $signed({2'b00, a_q[MAN_W +: EXP_W]}) - $signed({2'b00, b_q[MAN_W +: EXP_W]}) + BIAS;

  always_comb begin
    spec_res = '0;
    spec_flg = '0;
    special  = 1'b1;
    if (a_nan | b_nan | (a_z & b_z) | (a_inf & b_inf)) begin
      spec_res = W'(fp_qnan(EXP_W, MAN_W));
      spec_flg[FLAG_INVALID] = 1'b1;
    end else if (b_z & ~a_inf) begin
      spec_res = W'(fp_inf(sgn, EXP_W, MAN_W));
      spec_flg[FLAG_DIV_ZERO] = 1'b1;
    end else if (a_inf) begin
      spec_res = W'(fp_inf(sgn, EXP_W, MAN_W));
    end else if (a_z | b_inf) begin
      spec_res = W'(fp_zero(sgn, EXP_W, MAN_W));
    end else begin
      special = 1'b0;
    end
  end

  logic [RW:0]   diff;
  logic          trial_ge;
  logic [RW-1:0] rem_keep;

  assign diff     = {1'b0, rem} - {2'b00, div_sig};
  assign trial_ge = ~diff[RW];
  assign rem_keep = trial_ge ? diff[RW-1:0] : rem;

  logic                 guard, sticky, round_up, carry;
  logic [SW:0]          sum;
  logic [MAN_W-1:0]     frac;
  logic signed [XW-1:0] exp_r;
  logic [W-1:0]         rnd_res;
  logic [4:0]           rnd_flg;

  always_comb begin
    guard  = q_bits[0];
    sticky = |rem;
`ifdef FPDIV_ITER_ROUND_EN
    round_up = guard & (sticky | q_bits[1]);
`else
    round_up = 1'b0;
`endif
    sum   = {1'b0, q_bits[QW-1:1]} + {{SW{1'b0}}, round_up};
    carry = sum[SW];
    frac  = carry ? sum[MAN_W:1] : sum[MAN_W-1:0];
    exp_r = exp_work + $signed({{(XW-1){1'b0}}, carry});
    rnd_flg = '0;
    rnd_res = {sign_q, exp_r[EXP_W-1:0], frac};
    if (exp_r >= EXP_MAX) begin
`ifdef FPDIV_ITER_ROUND_EN
      rnd_res = W'(fp_inf(sign_q, EXP_W, MAN_W));
`else
      rnd_res = W'(fp_max_finite(sign_q, EXP_W, MAN_W));
`endif
      rnd_flg[FLAG_OVERFLOW] = 1'b1;
      rnd_flg[FLAG_INEXACT]  = 1'b1;
    end else if (exp_r[XW-1] || (exp_r == '0)) begin
      rnd_res = W'(fp_zero(sign_q, EXP_W, MAN_W));
      rnd_flg[FLAG_UNDERFLOW] = 1'b1;
      rnd_flg[FLAG_INEXACT]   = 1'b1;
    end else begin
      rnd_flg[FLAG_INEXACT] = guard | sticky;
    end
  end

  // Specials also pass through ROUND so their result appears two edges after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      rem      <= '0;
      div_sig  <= '0;
      q_bits   <= '0;
      exp_work <= '0;
      sign_q   <= 1'b0;
      cnt      <= '0;
      bypass   <= 1'b0;
      spec_q   <= '0;
      spec_fq  <= '0;
      quotient <= '0;
      flags    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q   <= dividend;
            b_q   <= divisor;
            state <= ST_PREP;
          end
        end
        ST_PREP: begin
          sign_q  <= sgn;
          bypass  <= special;
          spec_q  <= spec_res;
          spec_fq <= spec_flg;
          if (special) begin
            state <= ST_ROUND;
          end else begin
            div_sig <= sig2;
            q_bits  <= '0;
            cnt     <= CW'(QW);
            if (sig1 < sig2) begin
              rem      <= {sig1, 1'b0};
              exp_work <= exp_pre - XW'(1);
            end else begin
              rem      <= {1'b0, sig1};
              exp_work <= exp_pre;
            end
            state <= ST_ITER;
          end
        end
        ST_ITER: begin
          rem    <= rem_keep << 1;
          q_bits <= {q_bits[QW-2:0], trial_ge};
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= ST_ROUND;
        end
        ST_ROUND: begin
          quotient <= bypass ? spec_q  : rnd_res;
          flags    <= bypass ? spec_fq : rnd_flg;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

endmodule

// File: tb/tb_fpdiv_iter.sv
// Self-checking bench for fpdiv_iter (default 8/23 widths); follows FPDIV_ITER_ROUND_EN if defined.
module tb_fpdiv_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [4:0]  flags;

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  fpdiv_iter #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] xp);
    n_vec++;
    if (act !== xp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, xp);
    end
  endtask

  // Reference: exact integer long division of the significands, then the rounding rules.
  function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b);
    logic sa, sb, s, za, zb, ia, ib, na, nb, g, st, inx;
    logic [7:0] ea, eb;
    logic [22:0] ma, mb;
    logic [63:0] num, den, qf, r, m;
    int e;
    sa = a[31]; ea = a[30:23]; ma = a[22:0];
    sb = b[31]; eb = b[30:23]; mb = b[22:0];
    s  = sa ^ sb;
    za = (ea == 8'h00); zb = (eb == 8'h00);
    ia = (ea == 8'hFF) && (ma == 0); ib = (eb == 8'hFF) && (mb == 0);
    na = (ea == 8'hFF) && (ma != 0); nb = (eb == 8'hFF) && (mb != 0);
    if (na || nb || (za && zb) || (ia && ib)) return {32'h7FC00000, 5'b10000};
    if (zb && !ia) return {s, 31'h7F800000, 5'b01000};
    if (ia) return {s, 31'h7F800000, 5'b00000};
    if (za || ib) return {s, 31'h0, 5'b00000};
    num = {40'd1, ma} << 26;
    den = {40'd1, mb};
    qf  = num / den;
    r   = num % den;
    e   = int'(ea) - int'(eb) + 127;
    if (qf >= (64'd1 << 26)) begin
      m = qf >> 3; g = qf[2]; st = (qf[1:0] != 2'b00) || (r != 0);
    end else begin
      e = e - 1;
      m = qf >> 2; g = qf[1]; st = qf[0] || (r != 0);
    end
    inx = g || st;
`ifdef FPDIV_ITER_ROUND_EN
    if (g && (st || m[0])) m = m + 1;
    if (m == (64'd1 << 24)) begin m = m >> 1; e = e + 1; end
`endif
    if (e >= 255) begin
`ifdef FPDIV_ITER_ROUND_EN
      return {s, 31'h7F800000, 5'b00101};
`else
      return {s, 31'h7F7FFFFF, 5'b00101};
`endif
    end
    if (e <= 0) return {s, 31'h0, 5'b00011};
    return {s, 8'(e), m[22:0], 4'b0000, inx};
  endfunction

  // Compare process: every cycle the result is presented it must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL mon_unexpected: got %0h expected no result", quotient);
      end else begin
        chk("mon_quotient", 64'(quotient), 64'(exp_q[0][36:5]));
        chk("mon_flags", 64'(flags), 64'(exp_q[0][4:0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input string nm);
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    dividend = a; divisor = b; in_valid = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int lat, input int hold,
                        input logic [31:0] xq, input logic [4:0] xf, input string nm);
    int n;
    logic [31:0] q0;
    logic [4:0]  f0;
    start_op(a, b, nm);
    n = 1;
    while (!out_valid && n < 100) begin @(posedge clk); #1; if (!out_valid) n++; end
    chk({nm, "_latency"}, 64'(n), 64'(lat));
    chk({nm, "_quotient"}, 64'(quotient), 64'(xq));
    chk({nm, "_flags"}, 64'(flags), 64'(xf));
    q0 = quotient; f0 = flags;
    repeat (hold) begin
      @(posedge clk); #1;
      chk({nm, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({nm, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      chk({nm, "_hold_q"}, 64'(quotient), 64'(q0));
      chk({nm, "_hold_f"}, 64'(flags), 64'(f0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_release_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_release_in_ready"}, 64'(in_ready), 64'd1);
  endtask

`ifdef FPDIV_ITER_ROUND_EN
  localparam logic [31:0] Q_THIRD = 32'h3EAAAAAB;
  localparam logic [31:0] Q_2_3   = 32'h3F2AAAAB;
  localparam logic [31:0] Q_OVF   = 32'h7F800000;
`else
  localparam logic [31:0] Q_THIRD = 32'h3EAAAAAA;
  localparam logic [31:0] Q_2_3   = 32'h3F2AAAAA;
  localparam logic [31:0] Q_OVF   = 32'h7F7FFFFF;
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("model_6_2", 64'(model(32'h40C00000, 32'h40000000)), {27'd0, 32'h40400000, 5'b00000});
    chk("model_1_3", 64'(model(32'h3F800000, 32'h40400000)), {27'd0, Q_THIRD, 5'b00001});
    chk("model_1_0", 64'(model(32'h3F800000, 32'h00000000)), {27'd0, 32'h7F800000, 5'b01000});
    chk("model_0_0", 64'(model(32'h00000000, 32'h00000000)), {27'd0, 32'h7FC00000, 5'b10000});
    chk("model_ovf", 64'(model(32'h7F7FFFFF, 32'h3F000000)), {27'd0, Q_OVF, 5'b00101});

    run_op(32'h40C00000, 32'h40000000, 27, 0, 32'h40400000, 5'b00000, "div_6_2");
    run_op(32'h3F800000, 32'h40400000, 27, 0, Q_THIRD,      5'b00001, "div_1_3");
    run_op(32'h40000000, 32'h40400000, 27, 0, Q_2_3,        5'b00001, "div_2_3");
    run_op(32'hC0F00000, 32'h40200000, 27, 0, 32'hC0400000, 5'b00000, "div_neg");
    run_op(32'h3F800000, 32'h00000000, 2,  0, 32'h7F800000, 5'b01000, "div_by_zero");
    run_op(32'h00000000, 32'h00000000, 2,  0, 32'h7FC00000, 5'b10000, "zero_zero");
    run_op(32'h7F800000, 32'h7F800000, 2,  0, 32'h7FC00000, 5'b10000, "inf_inf");
    run_op(32'hBF800000, 32'h7FC00001, 2,  0, 32'h7FC00000, 5'b10000, "nan_in");
    run_op(32'hFF800000, 32'h40000000, 2,  0, 32'hFF800000, 5'b00000, "inf_fin");
    run_op(32'h40000000, 32'hFF800000, 2,  0, 32'h80000000, 5'b00000, "fin_inf");
    run_op(32'h00000001, 32'h3F800000, 2,  0, 32'h00000000, 5'b00000, "daz_sub");
    run_op(32'h7F7FFFFF, 32'h3F000000, 27, 0, Q_OVF,        5'b00101, "overflow");
    run_op(32'h00800000, 32'h40000000, 27, 0, 32'h00000000, 5'b00011, "underflow");

    run_op(32'h40C00000, 32'h40000000, 27, 5, 32'h40400000, 5'b00000, "bp_first");
    run_op(32'h3F800000, 32'h40400000, 27, 0, Q_THIRD,      5'b00001, "bp_second");

    start_op(32'h40C00000, 32'h40000000, "abort");
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_quotient", 64'(quotient), 64'd0);
    chk("abort_flags", 64'(flags), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    run_op(32'h40C00000, 32'h40000000, 27, 0, 32'h40400000, 5'b00000, "after_abort");

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
